pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Drives the 8-bit program_counter input of mips_core. It replaces hand-stepped PC stimulus with a clocked fetch sequencer. Each PC value is held for a fixed number of clocks, then the sequencer advances sequentially, by a PC-relative branch, or to an absolute jump target. It stops at a programmed last address. It sits between the top-level control (start, stall) and the core's instruction-memory index.

Parameters:
PC_WIDTH, 8, width of program_counter and all address/offset ports
CYCLES_PER_INSTR, 4, clocks each PC value is presented (>=1)
RESET_PC, 0, first address issued after start
LAST_PC, 14, address whose sequential retirement ends the program

Ports:
clock  in  1  rising-edge system clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  launch program (sampled in IDLE or DONE only)
stall  in  1  freeze hold counter; PC and state unchanged
branch_taken  in  1  take PC-relative branch at retire
branch_offset  in  PC_WIDTH  signed two's-complement offset relative to PC+1
jump  in  1  take absolute jump at retire
jump_target  in  PC_WIDTH  absolute jump address
program_counter  out  PC_WIDTH  address presented to mips_core
instr_strobe  out  1  one-cycle pulse in the first cycle a new PC is presented
retire  out  1  high in the cycle the current PC completes
busy  out  1  high in RUN
done  out  1  high in DONE

Behaviour:
- Reset (async assert, sync-to-clock deassert irrelevant; takes effect immediately): state=IDLE, program_counter=RESET_PC, hold_cnt=0, instr_strobe=0, retire=0, busy=0, done=0. Applies mid-run too; any in-flight instruction is abandoned.
- States: IDLE, RUN, DONE.
- IDLE: outputs idle. start=1 at edge -> RUN, pc=RESET_PC, hold_cnt=0, instr_strobe=1 for the following cycle.
- RUN: busy=1. retire (combinational) = (hold_cnt==CYCLES_PER_INSTR-1) && !stall.
  - stall=1: hold_cnt, pc, state frozen; retire=0. This also applies in the would-be retire cycle.
  - Otherwise, when not retiring: hold_cnt+1.
  - On retire: hold_cnt=0, instr_strobe=1 next cycle. Next pc is selected by priority:
    1. jump -> jump_target
    2. branch_taken -> pc+1+branch_offset, modulo 2^PC_WIDTH
    3. pc==LAST_PC -> state DONE, pc held, instr_strobe not pulsed
    4. else pc+1, modulo 2^PC_WIDTH (255 wraps to 0)
  - jump, branch_taken and their operands are sampled only in the retire cycle and ignored otherwise.
  - A jump or branch taken from LAST_PC continues running.
- start in RUN is ignored.
- DONE: done=1, busy=0, program_counter holds LAST_PC. start=1 -> relaunch exactly as from IDLE (pc=RESET_PC, strobe).
- Timing: each unstalled PC is held exactly CYCLES_PER_INSTR clocks. With CYCLES_PER_INSTR=1, every unstalled RUN cycle retires and instr_strobe stays high while advancing.
- instr_strobe and program_counter are registered. retire is combinational from registered state and stall.

Decomposition:
- Shared package: state encoding (IDLE/RUN/DONE) and the PC_WIDTH default constant, reused by mips_core's fetch path.
- One natural sub-module: pc_next_calc (combinational next-PC select: jump/branch/increment with wrap). The FSM and hold counter stay in pc_sequencer.

Test Plan:
- Straight-line run, defaults: start pulse -> PC 0..14 each held 4 clocks, 15 instr_strobe pulses, done rises 60 clocks after the start edge, PC holds 14.
- Stall: stall=1 for 5 cycles while PC=3, hold_cnt=3 -> no retire during the stall, PC=3 held 9 clocks total, advances to 4 on first unstalled cycle.
- Branch: at retire of PC=5 with branch_taken=1, offset=-4 (8'hFC) -> next PC=2. At PC=6 with offset=+3 -> next PC=10.
- Jump priority: retire of PC=7 with jump=1, jump_target=12, branch_taken=1, offset=+1 -> next PC=12. Jump at PC=14 to 0 -> stays RUN, no done.
- Wrap: RESET_PC=254, LAST_PC=3 -> sequence 254, 255, 0, 1, 2, 3, then done.
- Reset mid-run: reset_n low while PC=9 mid-hold -> same cycle PC=0, busy=0, done=0, state IDLE. After release, no activity until start.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared fetch-sequencer definitions: FSM state encoding and default PC width.
// Used by pc_sequencer and by the core's fetch path.
// No logic; no latency or backpressure of its own.
package pc_sequencer_pkg;

    localparam int PC_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_next_calc.sv
// Next-PC select at retire: jump, then PC-relative branch, then end-of-program, then increment.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module pc_next_calc
    import pc_sequencer_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF,
    parameter int LAST_PC  = 14
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_offset,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic                finish
);

    localparam logic [PC_WIDTH-1:0] PC_ONE  = PC_WIDTH'(1);
    localparam logic [PC_WIDTH-1:0] PC_LAST = PC_WIDTH'(LAST_PC);

    logic [PC_WIDTH-1:0] pc_inc;

    // Two's-complement add at PC_WIDTH gives the signed offset and wrap for free.
    assign pc_inc = pc + PC_ONE;

    always_comb begin
        next_pc = pc_inc;
        finish  = 1'b0;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = pc_inc + branch_offset;
        end else if (pc == PC_LAST) begin
            next_pc = pc;
            finish  = 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: presents each PC for CYCLES_PER_INSTR clocks, then steps/branches/jumps until LAST_PC retires.
// Latency: PC and instr_strobe are registered (one clock after start/retire); retire is combinational.
// Backpressure: stall freezes hold counter, PC and state; retire is suppressed while stalled.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PC_WIDTH         = PC_WIDTH_DEF,
    parameter int CYCLES_PER_INSTR = 4,
    parameter int RESET_PC         = 0,
    parameter int LAST_PC          = 14
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_offset,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    output logic [PC_WIDTH-1:0] program_counter,
    output logic                instr_strobe,
    output logic                retire,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W = (CYCLES_PER_INSTR > 1) ? $clog2(CYCLES_PER_INSTR) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(CYCLES_PER_INSTR - 1);
    localparam logic [PC_WIDTH-1:0] PC_RST   = PC_WIDTH'(RESET_PC);

    seq_state_t          state, state_nxt;
    logic [PC_WIDTH-1:0] pc_q, pc_nxt;
    logic [CNT_W-1:0]    hold_cnt, cnt_nxt;
    logic                strobe_nxt;
    logic [PC_WIDTH-1:0] calc_pc;
    logic                calc_finish;

    pc_next_calc #(
        .PC_WIDTH (PC_WIDTH),
        .LAST_PC  (LAST_PC)
    ) u_next_calc (
        .pc            (pc_q),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .next_pc       (calc_pc),
        .finish        (calc_finish)
    );

    assign retire          = (state == ST_RUN) && (hold_cnt == CNT_LAST) && !stall;
    assign busy            = (state == ST_RUN);
    assign done            = (state == ST_DONE);
    assign program_counter = pc_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            pc_q         <= PC_RST;
            hold_cnt     <= '0;
            instr_strobe <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc_q         <= pc_nxt;
            hold_cnt     <= cnt_nxt;
            instr_strobe <= strobe_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc_q;
        cnt_nxt    = hold_cnt;
        strobe_nxt = 1'b0;
        case (state)
            ST_RUN: begin
                if (retire) begin
                    cnt_nxt = '0;
                    if (calc_finish) begin
                        state_nxt = ST_DONE;
                    end else begin
                        pc_nxt     = calc_pc;
                        strobe_nxt = 1'b1;
                    end
                end else if (!stall) begin
                    cnt_nxt = hold_cnt + 1'b1;
                end
            end
            // IDLE and DONE both launch identically on start.
            default: begin
                if (start) begin
                    state_nxt  = ST_RUN;
                    pc_nxt     = PC_RST;
                    cnt_nxt    = '0;
                    strobe_nxt = 1'b1;
                end
            end
        endcase
    end

endmodule
